// File: rtl/wb_arbiter.sv
// Purpose: arbitrates register-file writeback between pipeline (A) and long-latency unit (B), with anti-starvation.
// Latency: write port and b_ready are combinational; stall_req and scoreboard update one cycle after the edge.
// Backpressure: B is held off via b_ready; A is never held except through registered stall_req while B is forced.
// Optional feature: define WB_ARBITER_SCOREBOARD_EN to enable the pending-writeback busy scoreboard.
module wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        a_we,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        rd_busy1,
  output logic        rd_busy2,
  output logic        WriteEnable,
  output logic [4:0]  WriteAddress,
  output logic [31:0] WriteData,
  output logic        stall_req
);

  localparam int            CW       = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  logic a_req;
  logic force_b;
  logic b_xfer;
  logic b_denied;

  // A writing to r0 is a no-op and leaves the port free for B.
  assign a_req    = a_we && (a_addr != 5'd0);
  assign force_b  = (state == S_FORCE);
  // B wins when A is idle or when B has waited long enough; nothing moves in reset or while frozen.
  assign b_ready  = reset && ready && b_valid && (!a_req || force_b);
  assign b_xfer   = b_valid && b_ready;
  assign b_denied = ready && b_valid && !b_ready;

  // State register: FSM, starvation counter and the registered stall request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      stall_req <= (state_nxt == S_FORCE);
    end
  end

  // Next-state logic; ready=0 leaves everything untouched.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (ready) begin
      case (state)
        S_IDLE: begin
          if (b_denied) begin
            // A single allowed wait means the first denial already forces B.
            state_nxt    = (MAX_WAIT == 1) ? S_FORCE : S_WAIT;
            wait_cnt_nxt = '0;
          end
        end
        S_WAIT: begin
          if (b_xfer || !b_valid) begin
            state_nxt    = S_IDLE;
            wait_cnt_nxt = '0;
          end else if (b_denied) begin
            if (wait_cnt == CNT_LAST) begin
              state_nxt = S_FORCE;
            end else begin
              wait_cnt_nxt = wait_cnt + CW'(1);
            end
          end
        end
        S_FORCE: begin
          if (b_xfer || !b_valid) begin
            state_nxt    = S_IDLE;
            wait_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = S_IDLE;
          wait_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Write port mux: A first unless B is forced (then A is dropped), else B, else all zero.
  always_comb begin
    WriteEnable  = 1'b0;
    WriteAddress = 5'd0;
    WriteData    = 32'd0;
    if (reset && ready) begin
      if (a_req && !force_b) begin
        WriteEnable  = 1'b1;
        WriteAddress = a_addr;
        WriteData    = a_data;
      end else if (b_ready) begin
        WriteEnable  = (b_addr != 5'd0);
        WriteAddress = b_addr;
        WriteData    = b_data;
      end
    end
  end

`ifdef WB_ARBITER_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;

  // Decode this cycle's issue (set) and B writeback (clear) into one-hot masks.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (ready && issue_valid) busy_set[issue_addr] = 1'b1;
    if (b_xfer)               busy_clr[b_addr]     = 1'b1;
  end

  // Busy vector: set beats clear on the same register; r0 never busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (ready) begin
      busy <= ((busy & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
    end
  end

  assign rd_busy1 = reset && busy[rd_addr1];
  assign rd_busy2 = reset && busy[rd_addr2];
`else
  logic unused_sb;
  assign unused_sb = &{1'b0, issue_valid, issue_addr, rd_addr1, rd_addr2};
  assign rd_busy1  = 1'b0;
  assign rd_busy2  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vectors with literal checks plus a per-cycle reference model.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int MAXW   = 4;
  localparam int THRESH = (MAXW == 1) ? 1 : MAXW + 1;
`ifdef WB_ARBITER_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clock, reset, ready;
  logic        a_we, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, issue_addr, rd_addr1, rd_addr2;
  logic [31:0] a_data, b_data;
  logic        issue_valid, rd_busy1, rd_busy2;
  logic        WriteEnable, stall_req;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state: consecutive denied ready cycles and pending registers
  int denied;
  bit busy_m [32];

  wb_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .stall_req(stall_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ab(input logic we, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_we = we; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  // Per-cycle compare against the model, 1ns before each rising edge.
  initial begin
    bit        forced, areq;
    bit        e_brdy, e_we, e_stall, e_rb1, e_rb2;
    bit [4:0]  e_wa;
    bit [31:0] e_wd;
    denied = 0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    forever begin
      @(negedge clock);
      #4;
      forced  = (denied >= THRESH);
      areq    = a_we && (a_addr != 5'd0);
      e_brdy  = 1'b0; e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
      e_stall = reset && forced;
      e_rb1   = reset && SB && busy_m[rd_addr1];
      e_rb2   = reset && SB && busy_m[rd_addr2];
      if (reset && ready) begin
        if (areq && !forced) begin
          e_we = 1'b1; e_wa = a_addr; e_wd = a_data;
        end else if (b_valid) begin
          e_brdy = 1'b1; e_we = (b_addr != 5'd0); e_wa = b_addr; e_wd = b_data;
        end
      end
      chk("m_b_ready", b_ready, e_brdy);
      chk("m_we", WriteEnable, e_we);
      chk("m_waddr", WriteAddress, e_wa);
      chk("m_wdata", WriteData, e_wd);
      chk("m_stall", stall_req, e_stall);
      chk("m_rd_busy1", rd_busy1, e_rb1);
      chk("m_rd_busy2", rd_busy2, e_rb2);
      if (!reset) begin
        denied = 0;
        foreach (busy_m[i]) busy_m[i] = 1'b0;
      end else if (ready) begin
        if (b_valid && !e_brdy) denied++;
        else                    denied = 0;
        if (e_brdy) busy_m[b_addr] = 1'b0;
        if (issue_valid && issue_addr != 5'd0) busy_m[issue_addr] = 1'b1;
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    reset = 1'b0; ready = 1'b1;
    set_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0; issue_addr = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;

    // reset: activity on inputs must not reach the outputs
    @(negedge clock); set_ab(1'b1, 5'd5, 32'h1234, 1'b1, 5'd7, 32'h77); #2;
    chk("rst_we", WriteEnable, 0); chk("rst_waddr", WriteAddress, 0);
    chk("rst_b_ready", b_ready, 0); chk("rst_stall", stall_req, 0);

    // A only
    @(negedge clock); reset = 1'b1; set_ab(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0); #2;
    chk("a_we", WriteEnable, 1); chk("a_waddr", WriteAddress, 5);
    chk("a_wdata", WriteData, 32'h1234); chk("a_b_ready", b_ready, 0);

    // B with A writing r0 (ignored)
    @(negedge clock); set_ab(1'b1, 5'd0, 32'h5555, 1'b1, 5'd7, 32'hDEADBEEF); #2;
    chk("b_b_ready", b_ready, 1); chk("b_we", WriteEnable, 1);
    chk("b_waddr", WriteAddress, 7); chk("b_wdata", WriteData, 32'hDEADBEEF);

    // B to r0: handshake completes but no write
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE); #2;
    chk("b0_b_ready", b_ready, 1); chk("b0_we", WriteEnable, 0);

    // scoreboard: issue r9, later B writes r9 back
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b1; issue_addr = 5'd9; rd_addr1 = 5'd9; rd_addr2 = 5'd0; #2;
    chk("sb_c0", rd_busy1, 0);
    @(negedge clock); issue_valid = 1'b0; #2; chk("sb_c1", rd_busy1, SB);
    @(negedge clock); #2; chk("sb_c2", rd_busy1, SB);
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99); #2;
    chk("sb_c3_b_ready", b_ready, 1); chk("sb_c3", rd_busy1, SB);
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); #2;
    chk("sb_c4", rd_busy1, 0);
    // set and clear on the same register in one cycle: set wins
    @(negedge clock); issue_valid = 1'b1; issue_addr = 5'd9; #2;
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99); #2;
    chk("sb_reissue", rd_busy1, SB);
    @(negedge clock); issue_valid = 1'b0; set_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); #2;
    chk("sb_set_wins", rd_busy1, SB); chk("sb_r0", rd_busy2, 0);

    // starvation: A writes every cycle, B waits on r3
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock); set_ab(1'b1, 5'd2, 32'(c), 1'b1, 5'd3, 32'hB3); #2;
      chk("starve_b_ready", b_ready, 0); chk("starve_stall", stall_req, 0);
      chk("starve_waddr", WriteAddress, 2);
    end
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hB3); #2;
    chk("force_stall", stall_req, 1); chk("force_b_ready", b_ready, 1);
    chk("force_waddr", WriteAddress, 3);
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); #2;
    chk("force_exit_stall", stall_req, 0);

    // freeze in WAIT after three denials (count 2), marking r4 busy on the way
    rd_addr2 = 5'd4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock); set_ab(1'b1, 5'd2, 32'(c), 1'b1, 5'd6, 32'h66);
      issue_valid = (c == 1); issue_addr = 5'd4; #2;
      chk("wait_b_ready", b_ready, 0);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock); ready = 1'b0; issue_valid = 1'b0; #2;
      chk("frz_b_ready", b_ready, 0); chk("frz_we", WriteEnable, 0);
      chk("frz_stall", stall_req, 0);
    end
    @(negedge clock); ready = 1'b1; #2; chk("resume1_stall", stall_req, 0);
    @(negedge clock); #2; chk("resume2_stall", stall_req, 0);
    // now forced: A keeps writing and is dropped
    @(negedge clock); #2;
    chk("resume3_stall", stall_req, 1); chk("force_a_drop", WriteAddress, 6);
    chk("force2_b_ready", b_ready, 1); chk("force_busy4", rd_busy2, SB);
    // asynchronous reset mid-cycle, no clock edge in between
    #1; reset = 1'b0; #1;
    chk("arst_stall", stall_req, 0); chk("arst_busy4", rd_busy2, 0);
    chk("arst_b_ready", b_ready, 0); chk("arst_we", WriteEnable, 0);
    @(negedge clock);
    // pending B was dropped; A wins again from IDLE
    @(negedge clock); reset = 1'b1; #2;
    chk("post_rst_b_ready", b_ready, 0); chk("post_rst_stall", stall_req, 0);
    chk("post_rst_busy4", rd_busy2, 0);
    @(negedge clock); set_ab(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) @(negedge clock);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
